// File: rtl/apu_pkg.sv
// Shared APU definitions: waveform modes, register indices, length-counter load table.
// Pure declarations; no state, no handshake.
package apu_pkg;

   typedef enum logic [1:0] {
      TRI    = 2'd0,
      SAW_UP = 2'd1,
      SAW_DN = 2'd2,
      SQR    = 2'd3
   } wave_mode_t;

   localparam logic [1:0] REG_LIN = 2'd0;
   localparam logic [1:0] REG_EXT = 2'd1;
   localparam logic [1:0] REG_TLO = 2'd2;
   localparam logic [1:0] REG_THI = 2'd3;

   localparam int LEN_W = 8;

   // 5-bit length index to initial length count (2A03 length table).
   function automatic logic [LEN_W-1:0] len_lookup(input logic [4:0] idx);
      logic [LEN_W-1:0] v;
      case (idx)
         5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
         5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
         5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
         5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
         5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
         5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
         5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
         5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/apu_length_counter_gen2.sv
// Channel length counter: table load on write, decrement on length pulse unless halted.
// Count updates one clk after the strobe; a low enable clears the count and blocks loads.
module apu_length_counter_gen2
   import apu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       length_en,
   input  logic       length_halt,
   input  logic       length_pulse,
   input  logic       length_wren,
   input  logic [4:0] length_idx,
   output logic       length_nonzero
);

   logic [LEN_W-1:0] length_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         length_cnt <= '0;
      end else if (!length_en) begin
         length_cnt <= '0;
      end else if (length_wren) begin
         length_cnt <= len_lookup(length_idx);
      end else if (length_pulse && !length_halt && (length_cnt != '0)) begin
         length_cnt <= length_cnt - 1'b1;
      end
   end

   assign length_nonzero = (length_cnt != '0);

endmodule

// File: rtl/apu_wave_gen3.sv
// Triangle-style channel with selectable waveform, timer, sequencer, linear and length counters.
// Register writes land on the next clk; wave_out/active_out are combinational from that state.
module apu_wave_gen3
   import apu_pkg::*;
#(
   parameter int TIMER_W   = 11,
   parameter int SEQ_W     = 5,
   parameter int LIN_W     = 7,
   parameter int ULTRA_MIN = 2
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             chan_en,
   input  logic             cpu_clk,
   input  logic             l_pulse,
   input  logic             e_pulse,
   input  logic [1:0]       a_in,
   input  logic [7:0]       from_cpu,
   input  logic             wren,
   output logic [SEQ_W-2:0] wave_out,
   output logic             active_out
);

   localparam logic [TIMER_W-1:0] ULTRA_P = TIMER_W'(ULTRA_MIN);

   logic               ctrl;
   logic [LIN_W-1:0]   lin_reload;
   logic [LIN_W-1:0]   lin_cnt;
   logic               lin_flag;
   wave_mode_t         mode;
   logic [10:0]        period_lo;
   logic [TIMER_W-1:0] timer_period;
   logic [TIMER_W-1:0] timer_cnt;
   logic               timer_pulse;
   logic [SEQ_W-1:0]   seq;
   logic               len_nonzero;

   logic wr_lin, wr_ext, wr_tlo, wr_thi;
   assign wr_lin = wren && (a_in == REG_LIN);
   assign wr_ext = wren && (a_in == REG_EXT);
   assign wr_tlo = wren && (a_in == REG_TLO);
   assign wr_thi = wren && (a_in == REG_THI);

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl       <= 1'b0;
         lin_reload <= '0;
         mode       <= TRI;
         period_lo  <= '0;
      end else begin
         if (wr_lin) begin
            ctrl       <= from_cpu[7];
            lin_reload <= from_cpu[LIN_W-1:0];
         end
         if (wr_ext) mode <= wave_mode_t'(from_cpu[1:0]);
         if (wr_tlo) period_lo[7:0] <= from_cpu;
         if (wr_thi) period_lo[10:8] <= from_cpu[2:0];
      end
   end

   // Period bits above 10 only exist for wider timers and come from the extension register.
   if (TIMER_W > 11) begin : g_ext
      logic [TIMER_W-12:0] period_hi;
      always_ff @(posedge clk) begin
         if (rst)         period_hi <= '0;
         else if (wr_ext) period_hi <= from_cpu[TIMER_W-10:2];
      end
      assign timer_period = {period_hi, period_lo};
   end else begin : g_noext
      assign timer_period = period_lo;
   end

   assign timer_pulse = cpu_clk && (timer_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_cnt <= '0;
      end else if (cpu_clk) begin
         if (timer_cnt == '0) timer_cnt <= timer_period;
         else                 timer_cnt <= timer_cnt - 1'b1;
      end
   end

   // Very short periods would alias into an ultrasonic whine, so the sequencer freezes.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq <= '0;
      end else if (timer_pulse && active_out && (timer_period >= ULTRA_P)) begin
         seq <= seq + 1'b1;
      end
   end

   // Counter action sees the flag as it was before any same-cycle reg3 write.
   always_ff @(posedge clk) begin
      if (rst) begin
         lin_cnt  <= '0;
         lin_flag <= 1'b0;
      end else begin
         if (e_pulse) begin
            if (lin_flag)              lin_cnt <= lin_reload;
            else if (lin_cnt != '0)    lin_cnt <= lin_cnt - 1'b1;
         end
         if (wr_thi)                   lin_flag <= 1'b1;
         else if (e_pulse && !ctrl)    lin_flag <= 1'b0;
      end
   end

   apu_length_counter_gen2 u_len (
      .clk            (clk),
      .rst            (rst),
      .length_en      (chan_en),
      .length_halt    (ctrl),
      .length_pulse   (l_pulse),
      .length_wren    (wr_thi),
      .length_idx     (from_cpu[7:3]),
      .length_nonzero (len_nonzero)
   );

   assign active_out = (lin_cnt != '0) && len_nonzero;

   logic               seq_msb;
   logic [SEQ_W-2:0]   seq_lo;
   logic [SEQ_W-2:0]   seq_hi;
   assign seq_msb = seq[SEQ_W-1];
   assign seq_lo  = seq[SEQ_W-2:0];
   assign seq_hi  = seq[SEQ_W-1:1];

   always_comb begin
      wave_out = '0;
      case (mode)
         TRI:     wave_out = seq_msb ? seq_lo : ~seq_lo;
         SAW_UP:  wave_out = seq_hi;
         SAW_DN:  wave_out = ~seq_hi;
         SQR:     wave_out = {(SEQ_W-1){seq_msb}};
         default: wave_out = '0;
      endcase
   end

endmodule

// File: tb/tb_apu_wave_gen3.sv
// Directed bench for apu_wave_gen3: default instance plus a 13-bit timer instance on shared stimulus.
module tb_apu_wave_gen3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       chan_en = 1'b0;
   logic       cpu_clk = 1'b0;
   logic       l_pulse = 1'b0;
   logic       e_pulse = 1'b0;
   logic [1:0] a_in = 2'd0;
   logic [7:0] from_cpu = 8'd0;
   logic       wren = 1'b0;
   logic [3:0] wave_a, wave_b;
   logic       active_a, active_b;

   int n_vec  = 0;
   int n_miss = 0;
   int s;

   always #5 clk = ~clk;

   apu_wave_gen3 dut_a (
      .clk(clk), .rst(rst), .chan_en(chan_en), .cpu_clk(cpu_clk), .l_pulse(l_pulse),
      .e_pulse(e_pulse), .a_in(a_in), .from_cpu(from_cpu), .wren(wren),
      .wave_out(wave_a), .active_out(active_a)
   );

   apu_wave_gen3 #(.TIMER_W(13)) dut_b (
      .clk(clk), .rst(rst), .chan_en(chan_en), .cpu_clk(cpu_clk), .l_pulse(l_pulse),
      .e_pulse(e_pulse), .a_in(a_in), .from_cpu(from_cpu), .wren(wren),
      .wave_out(wave_b), .active_out(active_b)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wren = 1'b1; a_in = a; from_cpu = d;
      cyc();
      wren = 1'b0;
   endtask

   task automatic epulse();
      e_pulse = 1'b1;
      cyc();
      e_pulse = 1'b0;
   endtask

   task automatic lpulse();
      l_pulse = 1'b1;
      cyc();
      l_pulse = 1'b0;
   endtask

   task automatic cpu(input int n);
      cpu_clk = 1'b1;
      repeat (n) cyc();
      cpu_clk = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
   endtask

   // Triangle at default width: 15..0 over steps 0..15, then 0..15 over 16..31.
   function automatic int tri_exp(input int step);
      int m;
      m = step % 32;
      return (m < 16) ? (15 - m) : (m - 16);
   endfunction

   initial begin
      // Reset state
      do_reset();
      chk("rst_wave_a", wave_a, 15);
      chk("rst_act_a", active_a, 0);
      chk("rst_wave_b", wave_b, 15);
      chk("rst_act_b", active_b, 0);

      // Triangle run, one step per 5 cpu cycles
      chan_en = 1'b1;
      wr(2'd2, 8'h04);
      wr(2'd3, 8'h08);
      wr(2'd0, 8'h7F);
      epulse();
      chk("tri_active", active_a, 1);
      chk("tri_seq0", wave_a, 15);
      cpu(1);
      s = 1;
      chk("tri_first", wave_a, 14);
      for (int k = 0; k < 33; k++) begin
         cpu(4);
         chk("tri_hold", wave_a, tri_exp(s));
         cpu(1);
         s++;
         chk("tri_step", wave_a, tri_exp(s));
      end

      // Ultrasonic guard: period 1 freezes, period 2 advances
      wr(2'd2, 8'h01);
      wr(2'd3, 8'h08);
      cpu(20);
      chk("ultra_frozen", wave_a, tri_exp(s));
      wr(2'd2, 8'h02);
      cpu(3);
      s++;
      chk("ultra_min_step", wave_a, tri_exp(s));

      // Linear counter countdown with ctrl=0
      wr(2'd0, 8'h03);
      wr(2'd3, 8'h08);
      epulse(); chk("lin_3", active_a, 1);
      epulse(); chk("lin_2", active_a, 1);
      epulse(); chk("lin_1", active_a, 1);
      epulse(); chk("lin_0", active_a, 0);
      cpu(9);
      chk("lin_seq_halt", wave_a, tri_exp(s));

      // reg3 write and e_pulse in one cycle: flag survives, counter used old flag
      wren = 1'b1; a_in = 2'd3; from_cpu = 8'h08; e_pulse = 1'b1;
      cyc();
      wren = 1'b0; e_pulse = 1'b0;
      chk("same_cyc_old_flag", active_a, 0);
      epulse(); chk("same_cyc_reload", active_a, 1);
      epulse(); epulse();
      chk("same_cyc_dec", active_a, 1);
      epulse(); chk("same_cyc_zero", active_a, 0);

      // ctrl=1 keeps the flag, reloading on every pulse
      wr(2'd0, 8'h83);
      wr(2'd3, 8'h08);
      repeat (5) epulse();
      chk("ctrl_reload", active_a, 1);

      // Length counter: index 3 loads 2; halted when ctrl=1
      wr(2'd0, 8'h7F);
      wr(2'd3, 8'h18);
      epulse();
      chk("len_loaded", active_a, 1);
      lpulse(); chk("len_1", active_a, 1);
      lpulse(); chk("len_0", active_a, 0);
      wr(2'd0, 8'hFF);
      wr(2'd3, 8'h18);
      epulse();
      repeat (3) lpulse();
      chk("len_halt", active_a, 1);

      // chan_en drop, blocked load, re-enable
      chan_en = 1'b0;
      cyc();
      chk("chan_off", active_a, 0);
      wr(2'd3, 8'h08);
      chk("chan_off_load", active_a, 0);
      chan_en = 1'b1;
      wr(2'd3, 8'h08);
      chk("chan_on_load", active_a, 1);

      // Reset mid-sequence overrides same-cycle activity
      wr(2'd2, 8'h04);
      cpu(12);
      rst = 1'b1; cpu_clk = 1'b1; e_pulse = 1'b1;
      wren = 1'b1; a_in = 2'd3; from_cpu = 8'h08;
      cyc();
      rst = 1'b0; cpu_clk = 1'b0; e_pulse = 1'b0; wren = 1'b0;
      chk("midrst_wave", wave_a, 15);
      chk("midrst_act", active_a, 0);
      cpu(5);
      chk("midrst_still", wave_a, 15);

      // Mode decode at seq 0 and seq 17
      wr(2'd2, 8'h04);
      wr(2'd3, 8'h08);
      wr(2'd0, 8'hFF);
      epulse();
      wr(2'd1, 8'h03); chk("sqr_s0", wave_a, 0);
      wr(2'd1, 8'h02); chk("sdn_s0", wave_a, 15);
      wr(2'd1, 8'h01); chk("sup_s0", wave_a, 0);
      wr(2'd1, 8'h00); chk("tri_s0", wave_a, 15);
      cpu(81);
      chk("tri_s17", wave_a, 1);
      wr(2'd1, 8'h01); chk("sup_s17", wave_a, 8);
      wr(2'd1, 8'h02); chk("sdn_s17", wave_a, 7);
      wr(2'd1, 8'h03); chk("sqr_s17", wave_a, 15);
      wr(2'd1, 8'hFD); chk("ext_ignored_mode", wave_a, 8);
      cpu(5);
      chk("ext_ignored_step", wave_a, 9);

      // 13-bit timer: reg1=0x0D gives period 3<<11 = 6144 and rising saw
      do_reset();
      chan_en = 1'b1;
      wr(2'd1, 8'h0D);
      wr(2'd2, 8'h00);
      wr(2'd3, 8'h08);
      wr(2'd0, 8'hFF);
      epulse();
      chk("w13_active", active_b, 1);
      chk("w13_s0", wave_b, 0);
      cpu(1);
      chk("w13_s1", wave_b, 0);
      cpu(6144);
      chk("w13_hold", wave_b, 0);
      cpu(1);
      chk("w13_s2", wave_b, 1);
      wr(2'd1, 8'h01);
      wr(2'd2, 8'h04);
      cpu(6145);
      s = 3;
      chk("w13_s3", wave_b, 1);
      for (int k = 0; k < 31; k++) begin
         cpu(5);
         s++;
         chk("w13_saw", wave_b, (s % 32) >> 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/apu_wave_gen3.md
APU_WAVE_GEN3 -- requirements
Module: apu_wave_gen3

Interface
REQ-001 SHALL have parameter TIMER_W, default 11, timer period width; legal range 11..17.
REQ-002 SHALL have parameter SEQ_W, default 5, sequencer width (2^SEQ_W steps); legal range 3..8.
REQ-003 SHALL have parameter LIN_W, default 7, linear counter width; legal range 1..7.
REQ-004 SHALL have parameter ULTRA_MIN, default 2, minimum timer period at which the sequencer advances.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port chan_en, input, 1, channel enable from the status register.
REQ-008 SHALL have port cpu_clk, input, 1, one-clk pulse per CPU cycle.
REQ-009 SHALL have port l_pulse, input, 1, length-counter clock pulse.
REQ-010 SHALL have port e_pulse, input, 1, quarter-frame (linear counter) pulse.
REQ-011 SHALL have port a_in, input, 2, register select.
REQ-012 SHALL have port from_cpu, input, 8, write data.
REQ-013 SHALL have port wren, input, 1, register write strobe.
REQ-014 SHALL have port wave_out, output, SEQ_W-1, channel sample.
REQ-015 SHALL have port active_out, output, 1, high when linear counter != 0 and length counter != 0.

Function
REQ-016 Reg0 write: ctrl <= from_cpu[7]; lin_reload <= from_cpu[LIN_W-1:0].
REQ-017 Reg1 write (new): mode <= from_cpu[1:0]; timer_period[TIMER_W-1:11] <= from_cpu[TIMER_W-10:2]; bits beyond TIMER_W ignored.
REQ-018 Reg2 write: timer_period[7:0] <= from_cpu.
REQ-019 Reg3 write: timer_period[10:8] <= from_cpu[2:0]; length load from from_cpu[7:3]; lin_flag set; timer count and sequencer untouched.
REQ-020 Timer: on cpu_clk, count==0 -> reload timer_period and assert timer_pulse that cycle; else decrement; no action without cpu_clk.
REQ-021 Sequencer: on timer_pulse while active_out=1 and timer_period >= ULTRA_MIN, increment modulo 2^SEQ_W; otherwise hold.
REQ-022 Linear counter, on e_pulse: lin_flag=1 -> load lin_reload; else nonzero -> decrement; zero stays zero.
REQ-023 On e_pulse with ctrl=0, clear lin_flag; reg3 write in the same cycle wins (flag stays set); the counter action uses the pre-write flag.
REQ-024 Length halt = ctrl; chan_en=0 clears the length counter at the next edge and blocks loads.
REQ-025 Mode 0 triangle: seq MSB=1 -> seq low bits, else their inverse (15..0,0..15 at default).
REQ-026 Mode 1 rising saw: wave_out = seq[SEQ_W-1:1].
REQ-027 Mode 2 falling saw: wave_out = ~seq[SEQ_W-1:1].
REQ-028 Mode 3 square: wave_out = all ones when seq MSB=1, else zero.
REQ-029 wave_out is combinational from seq and mode; a mode change takes effect the cycle after the write; the output holds its last value when inactive (no forced zero).

Reset
REQ-030 rst SHALL clear timer_period, timer count, seq, ctrl, lin_reload, linear counter, lin_flag and mode (triangle), plus the length counter.
REQ-031 Post-reset output: wave_out=all ones (triangle, seq=0), active_out=0.
REQ-032 rst asserted mid-operation SHALL override all writes and pulses in that cycle.

Structure
REQ-033 Shared package apu_pkg SHALL hold the mode encodings (TRI=0, SAW_UP=1, SAW_DN=2, SQR=3) and the register index constants REG_LIN=0, REG_EXT=1, REG_TLO=2, REG_THI=3.
REQ-034 The length counter SHALL be the existing apu_length_counter_gen2 instance, wired as: length_en=chan_en, length_halt=ctrl, from_cpu[7:3], length_wren=reg3 write.

Verification
REQ-035 Defaults, reg2=0x04, reg3=0x08, reg0=0x7F, e_pulse -> active_out=1; seq advances every 5 cpu_clk; wave_out goes 15,14,...,0,0,1,...,15.
REQ-036 reg2=0x01, reg3=0x08, counters loaded -> seq frozen, wave_out constant (ultrasonic guard).
REQ-037 reg0=0x03 (ctrl=0), reg3 write, 4 e_pulses -> linear 3,2,1,0; active_out falls after the 4th pulse; seq halts.
REQ-038 reg3 write and e_pulse in the same cycle, ctrl=0 -> lin_flag remains 1; the next e_pulse reloads.
REQ-039 TIMER_W=13, reg1=0x0D -> period bits [12:11]=3, mode=SAW_UP; wave_out rises 0..15 and wraps.
REQ-040 chan_en dropped while active -> active_out=0 next cycle; rst mid-sequence -> seq=0, wave_out=15.
